// File: rtl/axi_lite_write_regfile_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) shared by the register-file slave
// and whatever master drives it.
interface axi_lite_write_regfile_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi_lite_write_regfile.sv
// AXI4-Lite write slave: accepts AW and W in either order, commits byte-strobed
// writes into a flat register file and answers OKAY or SLVERR on B.
module axi_lite_write_regfile #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           ACLK,
    input  logic                           ARSTn,
    axi_lite_write_regfile_if.slave        s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HAVE_A = 2'd1,
        ST_HAVE_W = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic                           awready_q, awready_d;
    logic                           wready_q, wready_d;
    logic                           bvalid_q, bvalid_d;
    logic [1:0]                     bresp_q, bresp_d;
    logic [NUM_REGS-1:0]            wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [DATA_WIDTH-1:0]          data_q, data_d;
    logic [STRB_W-1:0]              strb_q, strb_d;

    logic                           aw_hs_s;
    logic                           w_hs_s;
    logic                           commit_s;
    logic [ADDR_WIDTH-1:0]          c_addr_s;
    logic [DATA_WIDTH-1:0]          c_data_s;
    logic [STRB_W-1:0]              c_strb_s;
    logic [31:0]                    idx_s;
    logic                           in_range_s;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Handshake tracking, commit selection, address decode and register update.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        commit_s   = 1'b0;
        c_addr_s   = addr_q;
        c_data_s   = data_q;
        c_strb_s   = strb_q;
        aw_hs_s    = s_axi.AWVALID && awready_q;
        w_hs_s     = s_axi.WVALID && wready_q;

        case (state_q)
            ST_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                    c_addr_s = s_axi.AWADDR;
                    c_data_s = s_axi.WDATA;
                    c_strb_s = s_axi.WSTRB;
                end else if (aw_hs_s) begin
                    state_d = ST_HAVE_A;
                    addr_d  = s_axi.AWADDR;
                end else if (w_hs_s) begin
                    state_d = ST_HAVE_W;
                    data_d  = s_axi.WDATA;
                    strb_d  = s_axi.WSTRB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HAVE_A: begin
                if (w_hs_s) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                    c_data_s = s_axi.WDATA;
                    c_strb_s = s_axi.WSTRB;
                end else begin
                    state_d = ST_HAVE_A;
                end
            end
            ST_HAVE_W: begin
                if (aw_hs_s) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                    c_addr_s = s_axi.AWADDR;
                end else begin
                    state_d = ST_HAVE_W;
                end
            end
            ST_RESP: begin
                if (s_axi.BREADY) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Upper address bits beyond the decoded range still count toward the index.
        idx_s      = 32'(c_addr_s >> OFF_BITS);
        in_range_s = (idx_s < 32'(NUM_REGS));

        if (commit_s) begin
            bvalid_d = 1'b1;
            bresp_d  = in_range_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            bresp_d = bresp_q;
        end

        for (int k = 0; k < NUM_REGS; k++) begin
            if (commit_s && in_range_s && (idx_s == 32'(k))) begin
                regs_d[k*DATA_WIDTH +: DATA_WIDTH] =
                    merge_bytes(regs_q[k*DATA_WIDTH +: DATA_WIDTH], c_data_s, c_strb_s);
                wr_pulse_d[k] = 1'b1;
            end else begin
                regs_d[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k*DATA_WIDTH +: DATA_WIDTH];
                wr_pulse_d[k] = 1'b0;
            end
        end

        awready_d = (state_d == ST_IDLE) || (state_d == ST_HAVE_W);
        wready_d  = (state_d == ST_IDLE) || (state_d == ST_HAVE_A);
    end

    // State, handshake outputs, latched beat and register file.
    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q    <= ST_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            regs_q     <= {NUM_REGS{RESET_VALUE}};
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
        end else begin
            state_q    <= state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign reg_q         = regs_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_write_regfile.sv
// Bench for axi_lite_write_regfile: 32-bit instance checked every cycle against a
// transaction-level model, plus a 64-bit instance checked with directed values.
module tb_axi_lite_write_regfile;

    logic ACLK;
    logic ARSTn;

    axi_lite_write_regfile_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus32 ();
    axi_lite_write_regfile_if #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) bus64 ();

    logic [16*32-1:0] reg_q32;
    logic [15:0]      wr_pulse32;
    logic [16*64-1:0] reg_q64;
    logic [15:0]      wr_pulse64;

    axi_lite_write_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_REGS(16)) dut32 (
        .ACLK(ACLK), .ARSTn(ARSTn), .s_axi(bus32.slave),
        .reg_q(reg_q32), .wr_pulse(wr_pulse32)
    );

    axi_lite_write_regfile #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .NUM_REGS(16)) dut64 (
        .ACLK(ACLK), .ARSTn(ARSTn), .s_axi(bus64.slave),
        .reg_q(reg_q64), .wr_pulse(wr_pulse64)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: pending beats, response flag, register array.
    logic        m_en;
    logic        m_aw_pend;
    logic [11:0] m_aw_addr;
    logic        m_w_pend;
    logic [31:0] m_w_data;
    logic [3:0]  m_w_strb;
    logic        m_bvalid;
    logic [1:0]  m_bresp;
    logic [15:0] m_pulse;
    logic [31:0] m_regs [16];

    task automatic model_reset();
        m_en = 1'b0; m_aw_pend = 1'b0; m_w_pend = 1'b0; m_aw_addr = '0;
        m_w_data = '0; m_w_strb = '0; m_bvalid = 1'b0; m_bresp = 2'b00; m_pulse = '0;
        for (int k = 0; k < 16; k++) m_regs[k] = 32'h0;
    endtask

    task automatic model_step();
        logic aw_rdy;
        logic w_rdy;
        int   idx;
        aw_rdy  = m_en && !m_aw_pend && !m_bvalid;
        w_rdy   = m_en && !m_w_pend && !m_bvalid;
        m_pulse = '0;
        if (m_bvalid && bus32.BREADY) m_bvalid = 1'b0;
        if (bus32.AWVALID && aw_rdy) begin
            m_aw_pend = 1'b1;
            m_aw_addr = bus32.AWADDR;
        end
        if (bus32.WVALID && w_rdy) begin
            m_w_pend = 1'b1;
            m_w_data = bus32.WDATA;
            m_w_strb = bus32.WSTRB;
        end
        if (m_aw_pend && m_w_pend) begin
            idx = int'(m_aw_addr) / 4;
            if (idx < 16) begin
                for (int b = 0; b < 4; b++)
                    if (m_w_strb[b]) m_regs[idx][8*b +: 8] = m_w_data[8*b +: 8];
                m_pulse[idx] = 1'b1;
                m_bresp = 2'b00;
            end else begin
                m_bresp = 2'b10;
            end
            m_bvalid  = 1'b1;
            m_aw_pend = 1'b0;
            m_w_pend  = 1'b0;
        end
        m_en = 1'b1;
    endtask

    task automatic model_compare();
        logic [511:0] flat;
        for (int k = 0; k < 16; k++) flat[k*32 +: 32] = m_regs[k];
        chk("awready", bus32.AWREADY, m_en && !m_aw_pend && !m_bvalid);
        chk("wready",  bus32.WREADY,  m_en && !m_w_pend && !m_bvalid);
        chk("bvalid",  bus32.BVALID,  m_bvalid);
        chk("bresp",   bus32.BRESP,   m_bresp);
        chk("wr_pulse", wr_pulse32,   m_pulse);
        chk("reg_q",   reg_q32,       flat);
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARSTn) model_reset();
            model_compare();
            if (ARSTn) model_step();
        end
    end

    task automatic cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic do_aw, input logic [11:0] a,
                        input logic do_w, input logic [31:0] d, input logic [3:0] s);
        logic aw_done;
        logic w_done;
        bus32.AWVALID = do_aw; bus32.AWADDR = a;
        bus32.WVALID  = do_w;  bus32.WDATA  = d; bus32.WSTRB = s;
        for (int n = 0; n < 20 && (bus32.AWVALID || bus32.WVALID); n++) begin
            @(negedge ACLK);
            aw_done = bus32.AWVALID && bus32.AWREADY;
            w_done  = bus32.WVALID && bus32.WREADY;
            cyc();
            if (aw_done) bus32.AWVALID = 1'b0;
            if (w_done)  bus32.WVALID  = 1'b0;
        end
        chk("handshake_timeout", {bus32.AWVALID, bus32.WVALID}, 2'b00);
        bus32.AWVALID = 1'b0;
        bus32.WVALID  = 1'b0;
    endtask

    initial begin
        ARSTn = 1'b0;
        bus32.AWADDR = '0; bus32.AWVALID = 1'b0; bus32.WDATA = '0; bus32.WSTRB = '0;
        bus32.WVALID = 1'b0; bus32.BREADY = 1'b1;
        bus64.AWADDR = '0; bus64.AWVALID = 1'b0; bus64.WDATA = '0; bus64.WSTRB = '0;
        bus64.WVALID = 1'b0; bus64.BREADY = 1'b1;
        repeat (3) cyc();
        @(negedge ACLK);
        chk("rst_awready", bus32.AWREADY, 1'b0);
        chk("rst_regs", reg_q32, 512'h0);
        cyc();
        ARSTn = 1'b1;
        cyc();

        // Simultaneous AW/W to 0x08.
        send(1'b1, 12'h008, 1'b1, 32'hDEADBEEF, 4'hF);
        @(negedge ACLK);
        chk("s1_bvalid", bus32.BVALID, 1'b1);
        chk("s1_bresp", bus32.BRESP, 2'b00);
        chk("s1_reg2", reg_q32[2*32 +: 32], 32'hDEADBEEF);
        chk("s1_pulse", wr_pulse32, 16'h0004);
        cyc();
        @(negedge ACLK);
        chk("s1_bvalid_drop", bus32.BVALID, 1'b0);
        chk("s1_pulse_drop", wr_pulse32, 16'h0000);
        cyc();

        // W first, AW three cycles later.
        send(1'b0, 12'h000, 1'b1, 32'h12345678, 4'hF);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) begin
                bus32.AWVALID = 1'b1;
                bus32.AWADDR  = 12'h004;
            end
            @(negedge ACLK);
            chk("s2_wready_low", bus32.WREADY, 1'b0);
            chk("s2_awready_high", bus32.AWREADY, 1'b1);
            cyc();
        end
        bus32.AWVALID = 1'b0;
        @(negedge ACLK);
        chk("s2_reg1", reg_q32[1*32 +: 32], 32'h12345678);
        chk("s2_pulse", wr_pulse32, 16'h0002);
        cyc();

        // Byte strobes on reg3.
        send(1'b1, 12'h00C, 1'b1, 32'hFFFFFFFF, 4'hF);
        send(1'b1, 12'h00C, 1'b1, 32'h00AA00BB, 4'b0101);
        @(negedge ACLK);
        chk("s3_reg3", reg_q32[3*32 +: 32], 32'hFFAAFFBB);
        cyc();

        // Out-of-range addresses and an all-zero strobe.
        send(1'b1, 12'h040, 1'b1, 32'hCAFEF00D, 4'hF);
        @(negedge ACLK);
        chk("s4_bresp", bus32.BRESP, 2'b10);
        chk("s4_pulse", wr_pulse32, 16'h0000);
        cyc();
        send(1'b1, 12'hFFC, 1'b1, 32'h55555555, 4'hF);
        send(1'b1, 12'h014, 1'b1, 32'h77777777, 4'h0);
        @(negedge ACLK);
        chk("s4_zero_strb_pulse", wr_pulse32, 16'h0020);
        chk("s4_zero_strb_reg5", reg_q32[5*32 +: 32], 32'h0);
        chk("s4_zero_strb_bresp", bus32.BRESP, 2'b00);
        cyc();

        // Response backpressure.
        bus32.BREADY = 1'b0;
        send(1'b1, 12'h018, 1'b1, 32'hA5A5A5A5, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("s5_bvalid_hold", bus32.BVALID, 1'b1);
            chk("s5_bresp_hold", bus32.BRESP, 2'b00);
            chk("s5_readies_low", {bus32.AWREADY, bus32.WREADY}, 2'b00);
            cyc();
        end
        bus32.BREADY = 1'b1;
        @(negedge ACLK);
        chk("s5_bvalid_last", bus32.BVALID, 1'b1);
        cyc();
        @(negedge ACLK);
        chk("s5_bvalid_gone", bus32.BVALID, 1'b0);
        chk("s5_readies_back", {bus32.AWREADY, bus32.WREADY}, 2'b11);
        cyc();

        // 64-bit instance: AW 0x10 selects reg2.
        bus64.AWVALID = 1'b1; bus64.AWADDR = 12'h010;
        bus64.WVALID  = 1'b1; bus64.WDATA  = 64'h0123456789ABCDEF; bus64.WSTRB = 8'hFF;
        for (int n = 0; n < 20 && !(bus64.AWREADY && bus64.WREADY); n++) @(negedge ACLK);
        chk("s64_ready", {bus64.AWREADY, bus64.WREADY}, 2'b11);
        cyc();
        bus64.AWVALID = 1'b0; bus64.WVALID = 1'b0;
        @(negedge ACLK);
        chk("s64_reg2", reg_q64[2*64 +: 64], 64'h0123456789ABCDEF);
        chk("s64_pulse", wr_pulse64, 16'h0004);
        chk("s64_bvalid", bus64.BVALID, 1'b1);
        chk("s64_bresp", bus64.BRESP, 2'b00);
        cyc();

        // Reset while holding an address beat.
        send(1'b1, 12'h01C, 1'b0, 32'h0, 4'h0);
        @(negedge ACLK);
        chk("s6_have_a", {bus32.AWREADY, bus32.WREADY}, 2'b01);
        cyc();
        ARSTn = 1'b0;
        @(negedge ACLK);
        chk("s6_regs", reg_q32, 512'h0);
        chk("s6_outs", {bus32.AWREADY, bus32.WREADY, bus32.BVALID, bus32.BRESP}, 5'b0);
        chk("s6_pulse", wr_pulse32, 16'h0000);
        chk("s6_reg64", reg_q64[2*64 +: 64], 64'h0);
        cyc();
        ARSTn = 1'b1;
        bus32.WVALID = 1'b1; bus32.WDATA = 32'h11111111; bus32.WSTRB = 4'hF;
        repeat (2) cyc();
        bus32.WVALID = 1'b0;
        repeat (3) cyc();
        @(negedge ACLK);
        chk("s6_no_resp", bus32.BVALID, 1'b0);
        chk("s6_reg7", reg_q32[7*32 +: 32], 32'h0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_write_regfile.md
# axi_lite_write_regfile

Parametrised AXI4-Lite write-channel slave that terminates the AW, W and B channels and commits writes into an internal register file of `NUM_REGS` words with per-byte strobes. It decodes addresses and returns `SLVERR` for out-of-range accesses. It accepts the address and data channels independently and in either order. It sits between the AXI-Lite interconnect and control/status logic, which consumes the flattened register contents and per-register write pulses.

## Interface
- `DATA_WIDTH`, 32: bus and register width; legal values are 32 or 64.
- `ADDR_WIDTH`, 12: AWADDR width; must be ≥ clog2(NUM_REGS) + clog2(DATA_WIDTH/8).
- `NUM_REGS`, 16: number of registers; legal range 1..256.
- `RESET_VALUE`, 0: `DATA_WIDTH`-bit reset value applied to every register.
- ACLK  in  1  clock; all logic on the rising edge.
- ARSTn  in  1  reset, asynchronous, active-low.
- AWADDR  in  ADDR_WIDTH  write byte address.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready (registered).
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte enables; bit i qualifies WDATA[8i+7:8i].
- WVALID  in  1  data valid.
- WREADY  out  1  data ready (registered).
- BVALID  out  1  response valid (registered).
- BREADY  in  1  response ready.
- BRESP  out  2  response code: 00 = OKAY, 10 = SLVERR.
- reg_q  out  NUM_REGS*DATA_WIDTH  register file; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle strobe for a committed write to register k.

## Operation
- Index = AWADDR >> clog2(DATA_WIDTH/8).
  - Low byte-offset bits are ignored, so addresses are treated as word-aligned.
  - Index ≥ NUM_REGS selects the error path, including upper bits that lie beyond the decoded range.
- State machine: IDLE, HAVE_A, HAVE_W, RESP.
  - IDLE: AWREADY = 1, WREADY = 1.
    - AW handshake only → HAVE_A; latch AWADDR.
    - W handshake only → HAVE_W; latch WDATA and WSTRB.
    - Both handshakes in the same cycle → RESP; commit.
  - HAVE_A: AWREADY = 0, WREADY = 1. W handshake → RESP; commit.
  - HAVE_W: AWREADY = 1, WREADY = 0. AW handshake → RESP; commit.
  - RESP: AWREADY = 0, WREADY = 0, BVALID = 1. BVALID && BREADY → IDLE.
- Commit happens on the edge of the completing handshake.
  - In range: for each byte i with WSTRB[i] = 1, set reg[index][8i+7:8i] = WDATA byte i. Set wr_pulse[index] = 1 for one cycle. BRESP = 00.
  - Out of range: no register change, no wr_pulse, BRESP = 10.
  - WSTRB = 0 in range: no data change, wr_pulse still fires, BRESP = 00.
- Bytes whose strobe is 0 keep their previous value.
- Only one outstanding transaction; no new AW or W is accepted while in RESP.

## Timing
- Reset (ARSTn = 0) values:
  - AWREADY, WREADY, BVALID = 0; BRESP = 00; wr_pulse = 0.
  - Every register = RESET_VALUE; state = IDLE; latched address and data are cleared.
- First cycle after ARSTn deasserts: AWREADY = WREADY = 1.
- Reset asserted mid-transaction (any state) aborts it. No commit and no response are issued for the held beat.
- Handshake on edge T (the second channel, or both together):
  - reg_q updates, wr_pulse goes high and BVALID goes high, all visible in cycle T+1.
  - Ready for the next beat goes low in cycle T+1.
- BVALID and BRESP are held stable until BREADY is sampled high.
  - If BREADY is already high, BVALID lasts exactly 1 cycle.
  - AWREADY and WREADY return to 1 the cycle after the B handshake.
- Peak throughput: 1 write per 2 cycles (simultaneous AW/W, BREADY tied high).
- AWVALID held while in HAVE_A, or WVALID held while in HAVE_W, is not re-accepted. The beat waits for IDLE.
- wr_pulse is never asserted for more than 1 cycle per transaction.

## Test plan
- Reset, then AW 0x08 and W 0xDEADBEEF with WSTRB 0xF in the same cycle, BREADY = 1:
  - BVALID rises 1 cycle later and lasts 1 cycle; BRESP = 00.
  - reg2 = 0xDEADBEEF; wr_pulse = 0x0004 for 1 cycle.
- W before AW: W 0x12345678 / 0xF at cycle 0, AW 0x04 at cycle 3:
  - WREADY = 0 in cycles 1–3 (FSM in HAVE_W); AWREADY = 1.
  - reg1 = 0x12345678 after the cycle-3 edge.
- Byte strobes: reg3 = 0xFFFFFFFF, then write 0x00AA00BB with WSTRB 0b0101 → reg3 = 0xFFAAFFBB.
- Out of range: with NUM_REGS = 16, AW 0x40 → BRESP = 10, no wr_pulse, all registers unchanged.
- Backpressure: BREADY = 0 for 5 cycles → BVALID and BRESP stable, AWREADY = WREADY = 0 throughout; BREADY = 1 → BVALID drops the next cycle.
- Reset mid-operation: enter HAVE_A, then pulse ARSTn low → all outputs at reset values, registers = RESET_VALUE, no BVALID.
  - Repeat the first scenario with DATA_WIDTH = 64 and AW 0x10: reg2 is written with 64-bit data.
